// File: rtl/ula_pkg.sv
// Shared encodings for the ula issue stage: MIPS R-type fields,
// supported funct codes and the issue FSM states.
package ula_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'd0;
    localparam logic [5:0] FUNCT_ADD    = 6'd32;
    localparam logic [5:0] FUNCT_SUB    = 6'd34;
    localparam logic [5:0] FUNCT_MULT   = 6'd24;
    localparam logic [5:0] FUNCT_DIV    = 6'd26;

    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SH_LSB    = 6;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WB
    } state_t;

    function automatic logic is_legal(input logic [31:0] w);
        logic [5:0] f;
        f = w[FUNCT_LSB +: 6];
        return (w[OP_LSB +: 6] == OPCODE_RTYPE) &&
               (f == FUNCT_ADD || f == FUNCT_SUB ||
                f == FUNCT_MULT || f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/ula.sv
// ula: registered ALU (one clock latency); outputA[32] is the carry/borrow.
// Unknown operation codes produce 0.
module ula
    import ula_pkg::*;
(
    input  logic        clock,
    input  logic [31:0] inputA,
    input  logic [31:0] inputB,
    input  logic [5:0]  operation,
    output logic [32:0] outputA
);

    logic [63:0] prod;
    logic        unused_prod;

    assign prod        = 64'(inputA) * 64'(inputB);
    assign unused_prod = ^prod[63:33];

    always_ff @(posedge clock) begin
        case (operation)
            FUNCT_ADD:  outputA <= {1'b0, inputA} + {1'b0, inputB};
            FUNCT_SUB:  outputA <= {1'b0, inputA} - {1'b0, inputB};
            FUNCT_MULT: outputA <= prod[32:0];
            FUNCT_DIV:  outputA <= (inputB == '0) ? '0
                                   : {1'b0, inputA / inputB};
            default:    outputA <= '0;
        endcase
    end

endmodule

// File: rtl/ula_regfile.sv
// ula_regfile: NREGS x XLEN register file, three combinational reads,
// one synchronous write; r0 reads as zero and ignores writes.
module ula_regfile #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [4:0]      rs_addr,
    input  logic [4:0]      rt_addr,
    input  logic [4:0]      dbg_addr,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rs_data,
    output logic [XLEN-1:0] rt_data,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    assign rt_data  = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/ula_issue.sv
// ula_issue: one-at-a-time R-type issue/writeback stage feeding the ula ALU.
// Define ULA_OVERFLOW_TRAP_EN to trap signed add/sub overflow (adds `overflow`).
module ula_issue
    import ula_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] ula_inputA,
    output logic [XLEN-1:0] ula_inputB,
    output logic [5:0]      ula_operation,
    input  logic [XLEN:0]   ula_outputA,
    output logic            done,
    output logic            illegal,
    output logic            div_zero,
    output logic            carry,
`ifdef ULA_OVERFLOW_TRAP_EN
    output logic            overflow,
`endif
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    state_t          state;
    logic [4:0]      rd_q;
    logic            dz_q;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [5:0]      funct;
    logic            accept;
    logic            dz_now;
    logic            trap;
    logic            unused_shamt;

    assign funct        = instr[FUNCT_LSB +: 6];
    assign instr_ready  = (state == IDLE);
    assign accept       = instr_ready && instr_valid;
    assign dz_now       = (funct == FUNCT_DIV) && (rt_data == '0);
    assign unused_shamt = ^instr[SH_LSB +: 5];

    ula_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
        .clock    (clock),
        .reset_n  (reset_n),
        .rs_addr  (instr[RS_LSB +: 5]),
        .rt_addr  (instr[RT_LSB +: 5]),
        .dbg_addr (dbg_addr),
        .wr_en    ((state == WB) && !trap),
        .wr_addr  (rd_q),
        .wr_data  (ula_outputA[XLEN-1:0]),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .dbg_data (dbg_data)
    );

`ifdef ULA_OVERFLOW_TRAP_EN
    logic a_sign;
    logic b_sign;
    logic is_add;
    logic is_sub;
    logic r_sign;

    assign r_sign   = ula_outputA[XLEN-1];
    assign trap     = (state == WB) && (r_sign != a_sign) &&
                      ((is_add && a_sign == b_sign) ||
                       (is_sub && a_sign != b_sign));
    assign overflow = trap;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            is_add <= 1'b0;
            is_sub <= 1'b0;
        end else if (accept) begin
            a_sign <= rs_data[XLEN-1];
            b_sign <= rt_data[XLEN-1];
            is_add <= funct == FUNCT_ADD;
            is_sub <= funct == FUNCT_SUB;
        end
    end
`else
    assign trap = 1'b0;
`endif

    assign done     = (state == WB) && !trap;
    assign div_zero = (state == WB) && dz_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rd_q          <= '0;
            dz_q          <= 1'b0;
            ula_inputA    <= '0;
            ula_inputB    <= '0;
            ula_operation <= '0;
            illegal       <= 1'b0;
            carry         <= 1'b0;
        end else begin
            illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        rd_q <= instr[RD_LSB +: 5];
                        if (is_legal(instr)) begin
                            state         <= ISSUE;
                            ula_inputA    <= rs_data;
                            ula_inputB    <= rt_data;
                            dz_q          <= dz_now;
                            // ula's default case turns a zero divide into 0
                            ula_operation <= dz_now ? 6'd0 : funct;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state         <= WB;
                    ula_inputA    <= '0;
                    ula_inputB    <= '0;
                    ula_operation <= '0;
                end
                WB: begin
                    state <= IDLE;
                    dz_q  <= 1'b0;
                    if (!trap) carry <= ula_outputA[XLEN];
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_issue.sv
// Bench for ula_issue + ula: vector table with a pulse scoreboard,
// plus reset and mid-flight reset sequences.
module tb_ula_issue;
    import ula_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = '0;
    logic [31:0] ula_inputA;
    logic [31:0] ula_inputB;
    logic [5:0]  ula_operation;
    logic [32:0] alu_out;
    logic [32:0] ula_outputA;
    logic        done;
    logic        illegal;
    logic        div_zero;
    logic        carry;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
`ifdef ULA_OVERFLOW_TRAP_EN
    logic        overflow;
`endif

    // result override lets the bench preload registers through the ALU path
    logic        ovr_en = 1'b0;
    logic [32:0] ovr_val = '0;
    assign ula_outputA = ovr_en ? ovr_val : alu_out;

    always #5 clock = ~clock;

    ula_issue dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .ula_inputA    (ula_inputA),
        .ula_inputB    (ula_inputB),
        .ula_operation (ula_operation),
        .ula_outputA   (ula_outputA),
        .done          (done),
        .illegal       (illegal),
        .div_zero      (div_zero),
        .carry         (carry),
`ifdef ULA_OVERFLOW_TRAP_EN
        .overflow      (overflow),
`endif
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    ula u_alu (
        .clock     (clock),
        .inputA    (ula_inputA),
        .inputB    (ula_inputB),
        .operation (ula_operation),
        .outputA   (alu_out)
    );

    typedef struct {
        logic [31:0] instr;
        logic        ovr;
        logic [32:0] ovr_val;
        logic        ill;
        logic        dz;
        logic        chk_c;
        logic        c;
        logic [31:0] val;
    } vec_t;

    typedef struct {
        logic ill;
        logic dz;
        int   acc;
    } exp_t;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t me;
    vec_t tv[18];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic vec_t v(input logic [31:0] w, input logic o,
        input logic [32:0] ov, input logic il, input logic dz,
        input logic cc, input logic c, input logic [31:0] val);
        vec_t r;
        r.instr = w; r.ovr = o; r.ovr_val = ov; r.ill = il;
        r.dz = dz; r.chk_c = cc; r.c = c; r.val = val;
        return r;
    endfunction

    logic pulse;
    always_comb begin
        pulse = done || illegal || div_zero;
`ifdef ULA_OVERFLOW_TRAP_EN
        pulse = pulse || overflow;
`endif
    end

    always @(negedge clock) begin
        if (reset_n && pulse) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected pulse: done=%b illegal=%b div_zero=%b, required none",
                         done, illegal, div_zero);
            end else begin
                me = sb.pop_front();
                chk("illegal", 64'(illegal), 64'(me.ill));
                chk("done", 64'(done), 64'(!me.ill));
                chk("div_zero", 64'(div_zero), 64'(me.dz));
                chk("latency", 64'(cyc - me.acc), me.ill ? 64'd0 : 64'd1);
`ifdef ULA_OVERFLOW_TRAP_EN
                chk("overflow", 64'(overflow), 64'd0);
`endif
            end
        end
    end

    task automatic run_vec(input vec_t t, input int idx);
        exp_t e;
        int   k;
        ovr_en  = t.ovr;
        ovr_val = t.ovr_val;
        @(negedge clock);
        k = 0;
        while (!instr_ready && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk($sformatf("v%0d ready", idx), 64'(instr_ready), 64'd1);
        instr       = t.instr;
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        e.ill = t.ill;
        e.dz  = t.dz;
        e.acc = cyc;
        sb.push_back(e);
        if (t.ill) begin
            @(negedge clock);
            chk($sformatf("v%0d ready after illegal", idx),
                64'(instr_ready), 64'd1);
        end
        k = 0;
        while (sb.size() != 0 && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk($sformatf("v%0d retire", idx), 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clock);
        ovr_en = 1'b0;
        if (t.chk_c)
            chk($sformatf("v%0d carry", idx), 64'(carry), 64'(t.c));
        dbg_addr = t.instr[RD_LSB +: 5];
        #1;
        chk($sformatf("v%0d R%0d", idx, dbg_addr), 64'(dbg_data), 64'(t.val));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = v(mk(0, 0, 0, 1, FUNCT_SUB), 1, 33'd5, 0, 0, 1, 0, 32'd5);
        tv[1]  = v(mk(0, 0, 0, 2, FUNCT_SUB), 1, 33'd7, 0, 0, 0, 0, 32'd7);
        tv[2]  = v(mk(0, 1, 2, 3, FUNCT_ADD), 0, 33'd0, 0, 0, 1, 0, 32'd12);
        tv[3]  = v(mk(0, 0, 0, 1, FUNCT_SUB), 1, 33'd3, 0, 0, 0, 0, 32'd3);
        tv[4]  = v(mk(0, 0, 0, 2, FUNCT_SUB), 1, 33'd5, 0, 0, 0, 0, 32'd5);
        tv[5]  = v(mk(0, 1, 2, 4, FUNCT_SUB), 0, 33'd0, 0, 0, 0, 0, 32'hFFFF_FFFE);
        tv[6]  = v(mk(0, 0, 0, 1, FUNCT_SUB), 1, 33'd100, 0, 0, 0, 0, 32'd100);
        tv[7]  = v(mk(0, 0, 0, 5, FUNCT_SUB), 1, 33'd77, 0, 0, 0, 0, 32'd77);
        tv[8]  = v(mk(0, 0, 0, 2, FUNCT_ADD), 0, 33'd0, 0, 0, 1, 0, 32'd0);
        tv[9]  = v(mk(0, 1, 2, 5, FUNCT_DIV), 0, 33'd0, 0, 1, 1, 0, 32'd0);
        tv[10] = v(mk(6'h23, 1, 2, 3, FUNCT_ADD), 0, 33'd0, 1, 0, 0, 0, 32'd12);
        tv[11] = v(mk(0, 1, 2, 4, 6'h25), 0, 33'd0, 1, 0, 0, 0, 32'hFFFF_FFFE);
        tv[12] = v(mk(0, 1, 1, 6, FUNCT_MULT), 0, 33'd0, 0, 0, 0, 0, 32'd10000);
        tv[13] = v(mk(0, 6, 1, 7, FUNCT_DIV), 0, 33'd0, 0, 0, 0, 0, 32'd100);
        tv[14] = v(mk(0, 1, 1, 0, FUNCT_ADD), 1, 33'h1_0000_0009, 0, 0, 1, 1, 32'd0);
        tv[15] = v(mk(0, 3, 3, 9, FUNCT_ADD), 0, 33'd0, 0, 0, 1, 0, 32'd24);
        tv[16] = v(mk(0, 0, 0, 11, FUNCT_SUB), 1, 33'h0_FFFF_FFFF, 0, 0, 1, 0, 32'hFFFF_FFFF);
        tv[17] = v(mk(0, 11, 1, 12, FUNCT_ADD), 0, 33'd0, 0, 0, 1, 1, 32'd99);

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("reset ready", 64'(instr_ready), 64'd1);
        chk("reset pulses", {61'd0, done, illegal, div_zero}, 64'd0);
        chk("reset carry", 64'(carry), 64'd0);
        chk("reset ula ports", {26'd0, ula_operation, ula_inputA | ula_inputB}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("reset R%0d", a), 64'(dbg_data), 64'd0);
        end

        foreach (tv[i]) run_vec(tv[i], i);

        // reset while add r6,r1,r2 sits in ISSUE
        @(negedge clock);
        instr       = mk(0, 1, 2, 6, FUNCT_ADD);
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        @(negedge clock);
        chk("midflight issue A", 64'(ula_inputA), 64'd100);
        chk("midflight issue op", 64'(ula_operation), 64'(FUNCT_ADD));
        reset_n = 1'b0;
        #1;
        chk("midflight no done", 64'(done), 64'd0);
        repeat (2) @(negedge clock);
        chk("midflight held done", 64'(done), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("midflight ready", 64'(instr_ready), 64'd1);
        dbg_addr = 5'd6;
        #1;
        chk("midflight R6", 64'(dbg_data), 64'd0);
        dbg_addr = 5'd1;
        #1;
        chk("midflight R1 cleared", 64'(dbg_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
